// File: rtl/bp_nonsynth_branch_event_queue.sv
// Branch event queue: captures attaboy / redirect FE commands and periodic
// commit-window markers into a small circular buffer that a branch profiler
// drains over valid/yumi. Events lost to a full queue are counted.
module bp_nonsynth_branch_event_queue #(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 8,
  parameter int window_p      = 1000
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       freeze_i,
  input  logic                       fe_cmd_yumi_i,
  input  logic                       is_attaboy_i,
  input  logic                       is_redirect_i,
  input  logic [vaddr_width_p-1:0]   vaddr_i,
  input  logic [4:0]                 br_flags_i,
  input  logic                       commit_v_i,
  output logic                       v_o,
  output logic [vaddr_width_p+6:0]   data_o,
  input  logic                       yumi_i,
  output logic [15:0]                drop_cnt_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int rec_w_lp = vaddr_width_p + 7;
  localparam int cnt_w_lp = $clog2(window_p);
  localparam logic [cnt_w_lp-1:0] last_commit_lp = cnt_w_lp'(window_p - 1);

  // Queue storage and pointers (extra MSB is the wrap bit)
  logic [rec_w_lp-1:0] mem_q [els_p];
  logic [ptr_w_lp:0]   wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp:0]   rd_ptr_q, rd_ptr_d;

  // Window bookkeeping
  logic [cnt_w_lp-1:0] commit_cnt_q, commit_cnt_d;
  logic [15:0]         redir_cnt_q, redir_cnt_d;
  logic [15:0]         marker_cnt_q, marker_cnt_d;
  logic                marker_pend_q, marker_pend_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  // Combinational helpers
  logic                empty, full, deq_v, space_v;
  logic                branch_v, redirect_v, commit_v, window_done;
  logic                enq_branch, enq_marker, enq_v;
  logic [rec_w_lp-1:0] enq_data;
  logic [15:0]         redir_plus;
  logic [1:0]          drop_inc;
  logic [16:0]         drop_sum;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0])
               && (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]);

  // A yumi with nothing queued is ignored rather than corrupting the pointers.
  assign deq_v   = yumi_i & ~empty;
  assign space_v = ~full | deq_v;

  assign branch_v    = fe_cmd_yumi_i & (is_attaboy_i | is_redirect_i) & ~freeze_i;
  assign redirect_v  = fe_cmd_yumi_i & is_redirect_i & ~freeze_i;
  assign commit_v    = commit_v_i & ~freeze_i;
  assign window_done = commit_v & (commit_cnt_q == last_commit_lp);

  // Enqueue arbitration, window counters and drop accounting
  always_comb begin
    enq_branch    = branch_v & space_v;
    enq_marker    = marker_pend_q & ~branch_v & space_v;
    enq_v         = enq_branch | enq_marker;
    enq_data      = '0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    commit_cnt_d  = commit_cnt_q;
    redir_cnt_d   = redir_cnt_q;
    marker_cnt_d  = marker_cnt_q;
    marker_pend_d = marker_pend_q;
    drop_inc      = 2'd0;

    if (enq_branch) begin
      enq_data = {vaddr_i, (is_redirect_i ? 2'd1 : 2'd0), br_flags_i};
    end else if (enq_marker) begin
      enq_data = {vaddr_width_p'(marker_cnt_q), 2'd2, 5'b00000};
    end

    if (enq_v) wr_ptr_d = wr_ptr_q + (ptr_w_lp+1)'(1);
    if (deq_v) rd_ptr_d = rd_ptr_q + (ptr_w_lp+1)'(1);

    // Saturating redirect count including any redirect this cycle
    redir_plus = (redirect_v && (redir_cnt_q != 16'hFFFF)) ? redir_cnt_q + 16'd1
                                                            : redir_cnt_q;

    if (commit_v) begin
      commit_cnt_d = window_done ? '0 : commit_cnt_q + cnt_w_lp'(1);
    end

    if (enq_marker) marker_pend_d = 1'b0;

    if (window_done) begin
      // Same-cycle redirect belongs to the window that just closed.
      marker_cnt_d  = redir_plus;
      redir_cnt_d   = 16'd0;
      marker_pend_d = 1'b1;
      if (marker_pend_q && !enq_marker) drop_inc = drop_inc + 2'd1;
    end else begin
      redir_cnt_d = redir_plus;
    end

    if (branch_v && !space_v) drop_inc = drop_inc + 2'd1;

    drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_inc);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      commit_cnt_q  <= '0;
      redir_cnt_q   <= '0;
      marker_cnt_q  <= '0;
      marker_pend_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_cnt_q  <= commit_cnt_d;
      redir_cnt_q   <= redir_cnt_d;
      marker_cnt_q  <= marker_cnt_d;
      marker_pend_q <= marker_pend_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Record storage; contents are only visible through a valid head
  always_ff @(posedge clk_i) begin
    if (enq_v) mem_q[wr_ptr_q[ptr_w_lp-1:0]] <= enq_data;
  end

  assign v_o        = ~empty;
  assign data_o     = v_o ? mem_q[rd_ptr_q[ptr_w_lp-1:0]] : '0;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bp_nonsynth_branch_event_queue.sv
// Directed bench for the branch event queue with a 16-commit window.
module tb_bp_nonsynth_branch_event_queue;

  localparam int VW  = 39;
  localparam int ELS = 8;
  localparam int WIN = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          freeze = 1'b0;
  logic          fe_cmd_yumi = 1'b0;
  logic          is_attaboy = 1'b0;
  logic          is_redirect = 1'b0;
  logic [VW-1:0] vaddr = '0;
  logic [4:0]    br_flags = '0;
  logic          commit_v = 1'b0;
  logic          v_o;
  logic [VW+6:0] data_o;
  logic          yumi = 1'b0;
  logic [15:0]   drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int illegal_yumi = 0;

  bp_nonsynth_branch_event_queue #(
    .vaddr_width_p(VW), .els_p(ELS), .window_p(WIN)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze),
    .fe_cmd_yumi_i(fe_cmd_yumi), .is_attaboy_i(is_attaboy),
    .is_redirect_i(is_redirect), .vaddr_i(vaddr), .br_flags_i(br_flags),
    .commit_v_i(commit_v), .v_o(v_o), .data_o(data_o), .yumi_i(yumi),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // Consumer protocol monitor: yumi only while a record is offered
  always @(posedge clk) begin
    if (reset_n && yumi && !v_o) illegal_yumi++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("pass %s: 0x%0h", tag, obs);
    end
  endtask

  function automatic logic [63:0] rec(input logic [VW-1:0] va, input logic [1:0] kind,
                                      input logic [4:0] flags);
    logic [VW+6:0] r;
    r = {va, kind, flags};
    return 64'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    freeze = 1'b0; fe_cmd_yumi = 1'b0; is_attaboy = 1'b0; is_redirect = 1'b0;
    vaddr = '0; br_flags = '0; commit_v = 1'b0; yumi = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic ev(input logic redir, input logic [VW-1:0] va, input logic [4:0] fl);
    fe_cmd_yumi = 1'b1; is_attaboy = ~redir; is_redirect = redir;
    vaddr = va; br_flags = fl;
  endtask

  task automatic no_ev();
    fe_cmd_yumi = 1'b0; is_attaboy = 1'b0; is_redirect = 1'b0;
  endtask

  // Check head record, then take it in the next cycle
  task automatic pop(input string tag, input logic [63:0] exp);
    check({tag, "_v"}, 64'(v_o), 64'd1);
    check(tag, 64'(data_o), exp);
    if (v_o) yumi = 1'b1;
    step();
    yumi = 1'b0;
  endtask

  initial begin
    int k;
    // ---------------- reset with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      k = $urandom_range(0, 2);
      fe_cmd_yumi = 1'($urandom); is_attaboy = (k == 1); is_redirect = (k == 2);
      vaddr = VW'({$urandom, $urandom}); br_flags = 5'($urandom);
      commit_v = 1'($urandom); freeze = 1'($urandom);
      step();
    end
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    idle_inputs();
    reset_n = 1'b1;
    repeat (10) step();
    check("idle_v", 64'(v_o), 64'd0);

    // ---------------- single redirect
    do_reset();
    ev(1'b1, VW'(64'h8000_1000), 5'b00011);
    step();
    no_ev();
    pop("single", rec(VW'(64'h8000_1000), 2'd1, 5'b00011));
    check("single_empty", 64'(v_o), 64'd0);

    // ---------------- overflow
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ev(1'b0, VW'(32'h100 + i), 5'(i));
      step();
    end
    no_ev();
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_head", 64'(data_o), rec(VW'(32'h100), 2'd0, 5'd0));
    ev(1'b0, VW'(32'h200), 5'd0);
    yumi = 1'b1;
    step();
    no_ev(); yumi = 1'b0;
    check("ovf_drop_full_yumi", 64'(drop_cnt), 64'd2);
    for (int i = 1; i < 8; i++) pop($sformatf("ovf_pop%0d", i), rec(VW'(32'h100 + i), 2'd0, 5'(i)));
    pop("ovf_pop200", rec(VW'(32'h200), 2'd0, 5'd0));
    check("ovf_empty", 64'(v_o), 64'd0);

    // ---------------- window marker
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      commit_v = 1'b1;
      if (i == 3 || i == 9 || i == 15) ev(1'b1, VW'(32'h1000 + i), 5'd0); else no_ev();
      step();
    end
    commit_v = 1'b0; no_ev();
    step();
    pop("win_r3", rec(VW'(32'h1003), 2'd1, 5'd0));
    pop("win_r9", rec(VW'(32'h1009), 2'd1, 5'd0));
    pop("win_r15", rec(VW'(32'h100f), 2'd1, 5'd0));
    pop("win_marker3", rec(VW'(3), 2'd2, 5'd0));
    check("win_empty", 64'(v_o), 64'd0);
    for (int i = 0; i < WIN; i++) begin
      commit_v = 1'b1;
      if (i == 0) ev(1'b1, VW'(32'h2000), 5'd0); else no_ev();
      step();
    end
    commit_v = 1'b0; no_ev();
    step();
    pop("win2_r", rec(VW'(32'h2000), 2'd1, 5'd0));
    pop("win2_marker1", rec(VW'(1), 2'd2, 5'd0));

    // ---------------- priority: window closes during a branch burst
    do_reset();
    commit_v = 1'b1;
    repeat (WIN - 1) step();
    for (int i = 0; i < 4; i++) begin
      commit_v = (i == 0);
      ev(1'b0, VW'(32'h300 + i), 5'd1);
      step();
    end
    commit_v = 1'b0; no_ev();
    step();
    for (int i = 0; i < 4; i++) pop($sformatf("prio_br%0d", i), rec(VW'(32'h300 + i), 2'd0, 5'd1));
    pop("prio_marker", rec(VW'(0), 2'd2, 5'd0));
    check("prio_empty", 64'(v_o), 64'd0);

    // ---------------- marker replaced while queue full
    do_reset();
    for (int i = 0; i < ELS; i++) begin
      ev(1'b0, VW'(32'h700 + i), 5'd2);
      step();
    end
    no_ev();
    for (int i = 0; i < WIN; i++) begin
      commit_v = 1'b1;
      if (i == 5) ev(1'b1, VW'(32'h7ff), 5'd0); else no_ev();
      step();
    end
    no_ev();
    check("repl_drop1", 64'(drop_cnt), 64'd1);
    repeat (WIN) step();
    commit_v = 1'b0;
    check("repl_drop2", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < ELS; i++) pop($sformatf("repl_br%0d", i), rec(VW'(32'h700 + i), 2'd0, 5'd2));
    pop("repl_marker_new", rec(VW'(0), 2'd2, 5'd0));
    check("repl_empty", 64'(v_o), 64'd0);
    check("repl_drop_final", 64'(drop_cnt), 64'd2);

    // ---------------- freeze
    do_reset();
    ev(1'b0, VW'(32'h400), 5'd0); step();
    ev(1'b0, VW'(32'h401), 5'd0); step();
    no_ev();
    for (int i = 0; i < 10; i++) begin
      commit_v = 1'b1;
      if (i == 4) ev(1'b1, VW'(32'h500), 5'd0); else no_ev();
      step();
    end
    for (int i = 0; i < 20; i++) begin
      freeze = 1'b1; commit_v = 1'b1;
      if (i < 5) ev(1'b1, VW'(32'h600 + i), 5'd3); else no_ev();
      yumi = 1'b0;
      if (i == 0) check("frz_pop0", 64'(data_o), rec(VW'(32'h400), 2'd0, 5'd0));
      if (i == 1) check("frz_pop1", 64'(data_o), rec(VW'(32'h401), 2'd0, 5'd0));
      if (i == 2) check("frz_pop2", 64'(data_o), rec(VW'(32'h500), 2'd1, 5'd0));
      if (i < 3 && v_o) yumi = 1'b1;
      step();
    end
    idle_inputs();
    step();
    check("frz_no_rec", 64'(v_o), 64'd0);
    check("frz_drop", 64'(drop_cnt), 64'd0);
    commit_v = 1'b1;
    repeat (6) step();
    commit_v = 1'b0;
    check("frz_marker_not_yet", 64'(v_o), 64'd0);
    step();
    check("frz_marker_v", 64'(v_o), 64'd1);
    check("frz_marker", 64'(data_o), rec(VW'(1), 2'd2, 5'd0));

    check("illegal_yumi", 64'(illegal_yumi), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_nonsynth_branch_event_queue.md
# bp_nonsynth_branch_event_queue

Captures resolved-branch events (attaboy and PC-redirect FE commands) at the BE->FE command handshake, together with periodic commit-window markers, and buffers them as packed records for a downstream branch profiler or trace writer to drain over a valid/yumi interface. It decouples the profiler from the FE command channel's timing. It also counts events lost to queue overflow.

## Interface
- vaddr_width_p, 39: virtual address width; record payload width.
- els_p, 8: queue depth; power of 2, >= 2.
- window_p, 1000: commits per window marker; >= 16.
- clk_i  in  1  clock; all state updates on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- freeze_i  in  1  while high, no capture and all counters hold; drain still works.
- fe_cmd_yumi_i  in  1  FE command accepted this cycle.
- is_attaboy_i  in  1  accepted command is attaboy (qualified by fe_cmd_yumi_i).
- is_redirect_i  in  1  accepted command is PC redirection (qualified by fe_cmd_yumi_i); mutually exclusive with is_attaboy_i.
- vaddr_i  in  vaddr_width_p  command vaddr.
- br_flags_i  in  5  {src_ret, src_btb, is_jalr, is_jal, is_br} from forwarded branch metadata.
- commit_v_i  in  1  one instruction committed.
- v_o  out  1  record available.
- data_o  out  vaddr_width_p+7  record: [vaddr_width_p+6:7] payload, [6:5] kind, [4:0] flags.
- yumi_i  in  1  consumer takes head record; legal only when v_o.
- drop_cnt_o  out  16  records lost, saturating.

## Operation
- Branch event: fe_cmd_yumi_i & (is_attaboy_i | is_redirect_i) & ~freeze_i. Record: payload=vaddr_i, kind=0 (attaboy) or 1 (redirect), flags=br_flags_i.
- Window logic: commit counter 0..window_p-1 increments on commit_v_i & ~freeze_i; on commit at window_p-1 wraps to 0 and completes a window. Redirect counter (16-bit, saturating at 0xFFFF) counts redirect events; at window completion, pending marker captures redirect count including a same-cycle redirect, and redirect counter restarts at 0 (or 1 if... no: same-cycle redirect belongs to completed window, counter restarts at 0).
- Window marker record: payload = captured count zero-extended, kind=2, flags=0. Kind 3 never produced.
- Single enqueue port, priority: branch event first; pending marker enqueues only on a cycle with no branch event and space available.
- Space available: ~full | yumi_i (simultaneous dequeue frees a slot at full).
- Branch event without space: dropped, drop_cnt_o += 1.
- Window completes while a marker is still pending: older marker dropped, drop_cnt_o += 1, newer marker replaces it.
- drop_cnt_o saturates at 0xFFFF.
- FIFO: circular buffer, read/write pointers log2(els_p) bits plus wrap bit; full when pointers equal and wrap bits differ; empty when all equal. Pointers wrap from els_p-1 to 0.
- freeze_i does not flush queue or pending marker; pending marker may still enqueue during freeze.
- yumi_i while ~v_o: illegal; bench asserts it never occurs; RTL ignores it.

## Timing
- Reset (reset_n_i low, async): v_o=0, drop_cnt_o=0, pointers, commit/redirect counters and pending flag cleared; data_o=0 (head entry reads 0). Reset asserted mid-operation discards all queued and pending records immediately.
- Branch event accepted at edge t -> v_o=1 with that record after edge t (visible cycle t+1); no combinational bypass.
- Window completing at edge t: pending set after t; earliest enqueue at edge t+1; visible cycle t+2.
- yumi_i at edge t: head advances; next record on data_o in cycle t+1.
- Queue holds els_p records max; v_o stays high while non-empty.

## Test plan
- Reset: hold reset_n_i low 5 cycles with random inputs -> v_o=0, drop_cnt_o=0; release, idle 10 cycles -> v_o stays 0.
- Single event: redirect, vaddr=0x80001000, flags=5'b00011 -> next cycle v_o=1, data_o={0x80001000, 2'd1, 5'b00011}; yumi -> v_o=0.
- Overflow: els_p=8, yumi_i=0, 10 attaboys vaddr 0x100..0x109 -> 8 queued (0x100..0x107), drop_cnt_o=2; at full with yumi_i=1 and new event 0x200 accepted, drop_cnt_o stays 2.
- Window: window_p=16, 16 commits with 3 redirects (one on 16th commit), consumer draining -> 3 redirect records then marker payload=3, kind=2; next window redirect count starts at 0.
- Priority/contention: window completes on same edge as branch events for 4 consecutive cycles -> branch records first, marker after first idle cycle; second window completing before marker enqueues (queue full) -> drop_cnt_o +1, only newer marker delivered.
- Freeze: freeze_i=1, 20 commits and 5 redirects -> no records, counters unchanged; queued records still drain; drop_cnt_o unchanged.
